// File: rtl/uart_defs_pkg.sv
// Shared UART definitions for uart_tx and uart_rx: FSM states, the baud table and the divider helper.
// Both ends use baud_div so that they derive identical integer bit periods.
package uart_defs_pkg;

  localparam int unsigned DIV_W_MAX = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int unsigned BAUD_TABLE [8] = '{
    1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200
  };

  // Rounded integer divider; there is no fractional correction, so the residual error is accepted.
  function automatic logic [DIV_W_MAX-1:0] baud_div(input logic [2:0] sel,
                                                     input int unsigned clk_hz);
    longint unsigned baud;
    longint unsigned div;
    baud = 64'(BAUD_TABLE[sel]);
    div  = (64'(clk_hz) + baud / 64'd2) / baud;
    return DIV_W_MAX'(div);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Bundle between a byte producer and uart_tx: the byte handshake, the baud select and the line/status outputs.
interface uart_tx_if;
  logic [2:0] buad_set_i;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;
  logic       uart_tx_o;
  logic       tx_busy_o;
  logic       tx_done_o;

  modport master (
    output buad_set_i, tx_data_i, tx_valid_i,
    input  tx_ready_o, uart_tx_o, tx_busy_o, tx_done_o
  );

  modport slave (
    input  buad_set_i, tx_data_i, tx_valid_i,
    output tx_ready_o, uart_tx_o, tx_busy_o, tx_done_o
  );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period generator: latches the divider on load, counts 0..DIV-1 while enabled,
// and strobes bit_end_o on the last clock of each bit.
module uart_baud_gen
  import uart_defs_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DIV_W       = 17
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic       bit_end_o
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             at_end;

  assign at_end = (cnt_q == (div_q - DIV_W'(1)));

  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_i) begin
      div_d = DIV_W'(baud_div(sel_i, CLK_FREQ_HZ));
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = at_end ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o = en_i && at_end;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, sent as a start bit, 8 data bits LSB first and 1 stop bit.
// Defining UART_TX_PARITY_EN inserts an even-parity bit after the data bits (8E1).
//
//   state     | meaning
//   ST_IDLE   | line high, ready for a byte
//   ST_START  | start bit (low) for one bit period
//   ST_DATA   | data bits 0..7, LSB first
//   ST_PARITY | even parity bit (only with UART_TX_PARITY_EN)
//   ST_STOP   | stop bit (high); tx_done_o on its final clock
module uart_tx
  import uart_defs_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned DIV_W       = 17
) (
  input  logic      clk_i,
  input  logic      rst_i,
  uart_tx_if.slave  tx_if
);

  tx_state_e  state_q, state_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       uart_tx_q, uart_tx_d;
  logic       accept;
  logic       bit_end;
  logic       tx_done;
  logic       tx_ready;
  logic       tx_busy;
`ifdef UART_TX_PARITY_EN
  logic       parity_q, parity_d;
`endif

  assign accept = tx_if.tx_valid_i && (state_q == ST_IDLE);

  uart_baud_gen #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .DIV_W       (DIV_W)
  ) u_baud_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (accept),
    .en_i      (state_q != ST_IDLE),
    .sel_i     (tx_if.buad_set_i),
    .bit_end_o (bit_end)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_idx_q <= '0;
      uart_tx_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      uart_tx_q <= uart_tx_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_START;
          shreg_d   = tx_if.tx_data_i;
          bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^tx_if.tx_data_i;
`endif
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line value is computed from the next state so the pad sees a clean registered edge.
  always_comb begin
    uart_tx_d = 1'b1;
    case (state_d)
      ST_START:  uart_tx_d = 1'b0;
      ST_DATA:   uart_tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: uart_tx_d = parity_d;
`endif
      default:   uart_tx_d = 1'b1;
    endcase
    tx_done  = (state_q == ST_STOP) && bit_end;
    tx_ready = (state_q == ST_IDLE);
    tx_busy  = (state_q != ST_IDLE);
  end

  assign tx_if.uart_tx_o  = uart_tx_q;
  assign tx_if.tx_done_o  = tx_done;
  assign tx_if.tx_ready_o = tx_ready;
  assign tx_if.tx_busy_o  = tx_busy;

endmodule
